// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes one RV32I instruction into ALU operands and operation,
// and holds the result in a single-entry valid/ready register feeding execute.
module alu_issue_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [4:0]            out_alu_op,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic                  out_is_branch,
  output logic                  out_illegal
);

  localparam logic [4:0] ALU_ADD        = 5'd0;
  localparam logic [4:0] ALU_SUB        = 5'd1;
  localparam logic [4:0] ALU_SLL        = 5'd2;
  localparam logic [4:0] ALU_LT         = 5'd3;
  localparam logic [4:0] ALU_LTU        = 5'd4;
  localparam logic [4:0] ALU_XOR        = 5'd5;
  localparam logic [4:0] ALU_SRL        = 5'd6;
  localparam logic [4:0] ALU_SRA        = 5'd7;
  localparam logic [4:0] ALU_OR         = 5'd8;
  localparam logic [4:0] ALU_AND        = 5'd9;
  localparam logic [4:0] ALU_EQUALS     = 5'd10;
  localparam logic [4:0] ALU_NOT_EQUALS = 5'd11;
  localparam logic [4:0] ALU_GE         = 5'd12;
  localparam logic [4:0] ALU_GEU        = 5'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;
  logic [31:0] imm_i, imm_s, imm_u;
  logic unused_rs1_field;

  assign opcode   = in_instr[6:0];
  assign rd_field = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u    = {in_instr[31:12], 12'b0};
  assign unused_rs1_field = ^in_instr[19:15];

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]            op_q, op_d, rd_q;
  logic                  we_q, we_d, br_q, br_d, ill_q, ill_d;
  logic                  we_raw;

  // Shared OP/OP-IMM funct3 mapping; the alternate funct7 only changes ADD and SRL.
  function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_LT;
      3'b011:  arith_op = ALU_LTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    op_d   = ALU_ADD;
    a_d    = '0;
    b_d    = '0;
    we_raw = 1'b0;
    br_d   = 1'b0;
    ill_d  = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_d    = in_rs1_data;
        b_d    = in_rs2_data;
        we_raw = 1'b1;
        op_d   = arith_op(funct3, funct7 == F7_ALT);
        if (!(funct7 == F7_BASE ||
              (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
          ill_d = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a_d    = in_rs1_data;
        b_d    = DATA_WIDTH'(imm_i);
        we_raw = 1'b1;
        op_d   = arith_op(funct3, 1'b0);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          b_d = DATA_WIDTH'(in_instr[24:20]);
          if (funct3 == 3'b101 && funct7 == F7_ALT) begin
            op_d = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            ill_d = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        b_d    = DATA_WIDTH'(imm_u);
        we_raw = 1'b1;
      end
      OPC_AUIPC: begin
        a_d    = in_pc;
        b_d    = DATA_WIDTH'(imm_u);
        we_raw = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        a_d    = in_pc;
        b_d    = DATA_WIDTH'(4);
        we_raw = 1'b1;
        if (opcode == OPC_JALR && funct3 != 3'b000) ill_d = 1'b1;
      end
      OPC_BRANCH: begin
        a_d  = in_rs1_data;
        b_d  = in_rs2_data;
        br_d = 1'b1;
        case (funct3)
          3'b000:  op_d = ALU_EQUALS;
          3'b001:  op_d = ALU_NOT_EQUALS;
          3'b100:  op_d = ALU_LT;
          3'b101:  op_d = ALU_GE;
          3'b110:  op_d = ALU_LTU;
          3'b111:  op_d = ALU_GEU;
          default: ill_d = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        a_d    = in_rs1_data;
        b_d    = DATA_WIDTH'(imm_i);
        we_raw = 1'b1;
      end
      OPC_STORE: begin
        a_d = in_rs1_data;
        b_d = DATA_WIDTH'(imm_s);
      end
      default: ill_d = 1'b1;
    endcase
    // Illegal ops issue as a harmless zero-operand ADD with no side effects.
    if (ill_d) begin
      op_d   = ALU_ADD;
      a_d    = '0;
      b_d    = '0;
      we_raw = 1'b0;
      br_d   = 1'b0;
    end
    we_d = we_raw && (rd_field != 5'd0);
  end

  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      rd_q    <= '0;
      we_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_field;
      we_q    <= we_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_a         = a_q;
  assign out_b         = b_q;
  assign out_alu_op    = op_q;
  assign out_rd        = rd_q;
  assign out_rd_we     = we_q;
  assign out_is_branch = br_q;
  assign out_illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage against a decode-table reference model.
module tb_alu_issue_stage;

  localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2,  A_LT  = 5'd3;
  localparam logic [4:0] A_LTU = 5'd4,  A_XOR = 5'd5,  A_SRL = 5'd6,  A_SRA = 5'd7;
  localparam logic [4:0] A_OR  = 5'd8,  A_AND = 5'd9,  A_EQ  = 5'd10, A_NE  = 5'd11;
  localparam logic [4:0] A_GE  = 5'd12, A_GEU = 5'd13;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic        out_valid, out_rd_we, out_is_branch, out_illegal;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_alu_op, out_rd;

  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_v = 1'b0;
  exp_t exp_p = '0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference decode written straight from the RV32I field rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [4:0] ar_tbl [8];
    logic [4:0] br_tbl [8];
    int unsigned f3, f7, opc;
    logic [31:0] ii, is, iu;
    logic legal;
    ar_tbl = '{A_ADD, A_SLL, A_LT, A_LTU, A_XOR, A_SRL, A_OR, A_AND};
    br_tbl = '{A_EQ, A_NE, A_ADD, A_ADD, A_LT, A_GE, A_LTU, A_GEU};
    opc = 32'(ins[6:0]);
    f3  = 32'(ins[14:12]);
    f7  = 32'(ins[31:25]);
    ii  = ins[31] ? {20'hFFFFF, ins[31:20]} : {20'h0, ins[31:20]};
    is  = ins[31] ? {20'hFFFFF, ins[31:25], ins[11:7]} : {20'h0, ins[31:25], ins[11:7]};
    iu  = ins & 32'hFFFFF000;
    e = '0;
    e.rd = ins[11:7];
    legal = 1'b1;
    if (opc == 'h33) begin
      e.a = r1; e.b = r2; e.we = 1'b1; e.op = ar_tbl[f3];
      if (f7 == 'h20 && f3 == 0) e.op = A_SUB;
      else if (f7 == 'h20 && f3 == 5) e.op = A_SRA;
      else if (f7 != 0) legal = 1'b0;
    end else if (opc == 'h13) begin
      e.a = r1; e.b = ii; e.we = 1'b1; e.op = ar_tbl[f3];
      if (f3 == 1 || f3 == 5) begin
        e.b = 32'(ins[24:20]);
        if (f3 == 5 && f7 == 'h20) e.op = A_SRA;
        else if (f7 != 0) legal = 1'b0;
      end
    end else if (opc == 'h37) begin
      e.b = iu; e.we = 1'b1;
    end else if (opc == 'h17) begin
      e.a = pc; e.b = iu; e.we = 1'b1;
    end else if (opc == 'h6F || opc == 'h67) begin
      e.a = pc; e.b = 32'd4; e.we = 1'b1;
      if (opc == 'h67 && f3 != 0) legal = 1'b0;
    end else if (opc == 'h63) begin
      e.a = r1; e.b = r2; e.br = 1'b1; e.op = br_tbl[f3];
      if (f3 == 2 || f3 == 3) legal = 1'b0;
    end else if (opc == 'h03) begin
      e.a = r1; e.b = ii; e.we = 1'b1;
    end else if (opc == 'h23) begin
      e.a = r1; e.b = is;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      e.a = '0; e.b = '0; e.op = A_ADD; e.we = 1'b0; e.br = 1'b0; e.ill = 1'b1;
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      chk({tag, ".a"},   out_a, exp_p.a);
      chk({tag, ".b"},   out_b, exp_p.b);
      chk({tag, ".op"},  32'(out_alu_op), 32'(exp_p.op));
      chk({tag, ".we"},  32'(out_rd_we), 32'(exp_p.we));
      chk({tag, ".br"},  32'(out_is_branch), 32'(exp_p.br));
      chk({tag, ".ill"}, 32'(out_illegal), 32'(exp_p.ill));
      if (!exp_p.ill) chk({tag, ".rd"}, 32'(out_rd), 32'(exp_p.rd));
    end
  endtask

  // One cycle: check the state left by the previous edge, drive, then advance the model.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                      input logic rdy, input logic fl);
    logic can_take;
    @(negedge clk);
    check_outputs(tag);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    out_ready = rdy; flush = fl;
    #1;
    can_take = !exp_v || rdy;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(can_take));
    if (fl) exp_v = 1'b0;
    else if (v && can_take) begin
      exp_v = 1'b1;
      exp_p = ref_decode(ins, pc, r1, r2);
    end else if (rdy) exp_v = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [10];
    logic [31:0] w;
    int unsigned sel;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h33};
    w = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 10) w[6:0] = opcs[sel];
    case ($urandom_range(0, 3))
      0, 1:    w[31:25] = 7'h00;
      2:       w[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    #12;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.a", out_a, 32'd0);
    chk("reset.b", out_b, 32'd0);
    chk("reset.op", 32'(out_alu_op), 32'(A_ADD));
    chk("reset.rd_we", 32'(out_rd_we), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    step("addi",      1'b1, 32'hFFF08293, 32'h0, 32'd7, 32'd0, 1'b1, 1'b0);
    step("sub",       1'b1, 32'h402081B3, 32'h4, 32'd20, 32'd5, 1'b1, 1'b0);
    step("stall1",    1'b1, 32'h0020E463, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0);
    step("stall2",    1'b1, 32'h0020E463, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0);
    step("stall3",    1'b1, 32'h0020E463, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0);
    step("bltu",      1'b1, 32'h0020E463, 32'h8, 32'd1, 32'd2, 1'b1, 1'b0);
    step("br_f3_010", 1'b1, 32'h0020A463, 32'hC, 32'd1, 32'd2, 1'b1, 1'b0);
    step("srai",      1'b1, 32'h40325213, 32'h10, 32'h80000000, 32'd9, 1'b1, 1'b0);
    step("srai_bad",  1'b1, 32'h42325213, 32'h14, 32'h80000000, 32'd9, 1'b1, 1'b0);
    step("auipc",     1'b1, 32'h12345317, 32'h100, 32'd3, 32'd4, 1'b1, 1'b0);
    step("lui_x0",    1'b1, 32'h00001037, 32'h104, 32'd3, 32'd4, 1'b1, 1'b0);
    step("flush",     1'b1, 32'hFFF08293, 32'h108, 32'd7, 32'd0, 1'b1, 1'b1);
    step("idle",      1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step("rand", $urandom_range(0, 9) < 8, rand_instr(), $urandom & 32'hFFFFFFFC,
           $urandom, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    step("pre_rst1", 1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd1, 1'b0, 1'b0);
    step("pre_rst2", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 32'(out_valid), 32'd0);
    chk("async_rst.a", out_a, 32'd0);
    chk("async_rst.op", 32'(out_alu_op), 32'(A_ADD));
    exp_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    step("post_rst2", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
